sram_req_adapter: RTL

//   Request/response front-end for the single-port generic SRAM wrapper (1-cycle read latency, active-low CEN/WEN).

---
 rtl/sram_req_adapter.sv | 74 +++++++
 1 files changed

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: req/gnt + rvalid/rready front-end for a 1-cycle-latency single-port SRAM
module sram_req_adapter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  mem_cen_o,
  output logic [ADDR_WIDTH-1:0] mem_a_o,
  output logic                  mem_wen_o,
  output logic [DATA_WIDTH-1:0] mem_d_o,
  output logic [BE_WIDTH-1:0]   mem_ben_o,
  input  logic [DATA_WIDTH-1:0] mem_q_i
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = RESP_DEPTH > 1 ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(RESP_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RESP_DEPTH - 1);
  logic                  pend_q, pend_d, pend_we_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2**PW];
  logic [DATA_WIDTH-1:0] resp;
  logic                  push, pop, empty;
  always_comb begin
    empty     = cnt_q == '0;
    resp      = pend_we_q ? '0 : mem_q_i;
    // credit counts the in-flight access so a response always has a slot
    gnt_o     = req_i & ~RST & (({1'b0, cnt_q} + {{CW{1'b0}}, pend_q}) < {1'b0, FULL});
    pend_d    = req_i & gnt_o;
    push      = pend_q & ~(empty & rready_i);
    pop       = ~empty & rready_i;
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    wptr_d    = push ? (wptr_q == LAST ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d    = pop ? (rptr_q == LAST ? '0 : rptr_q + 1'b1) : rptr_q;
    rvalid_o  = ~empty | pend_q;
    rdata_o   = ~empty ? fifo_q[rptr_q] : (pend_q ? resp : '0);
    mem_cen_o = ~pend_d;
    mem_a_o   = add_i;
    mem_wen_o = ~we_i;
    mem_d_o   = wdata_i;
    mem_ben_o = be_i;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_q    <= 1'b0;
      pend_we_q <= 1'b0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      pend_q    <= pend_d;
      pend_we_q <= we_i;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wptr_q] <= resp;
  end
  overflow_chk: assert property (@(posedge CLK) disable iff (RST) !(push && cnt_q == FULL));
endmodule
